// File: rtl/vga_bounce_gfx_if.sv
// Pixel-bus bundle between the VGA timing stage (master) and the colour generator (slave).
interface vga_bounce_gfx_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       pause;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       frame_tick;

  modport master (output hc, vc, pause, input red, green, blue, frame_tick);
  modport slave  (input hc, vc, pause, output red, green, blue, frame_tick);
endinterface

// File: rtl/vga_bounce_gfx.sv
// Bouncing-box RGB332 pixel generator, colour registered one pixel ahead of hc/vc.
// Optional 1-pixel white frame around the visible area: define VGA_BOUNCE_BORDER_EN.
module vga_bounce_gfx #(
  parameter int unsigned BOX_W    = 32,
  parameter int unsigned BOX_H    = 32,
  parameter int unsigned STEP     = 2,
  parameter logic [7:0]  BG_COLOR = 8'h00
) (
  input  logic             vgaclk,
  input  logic             rst,
  vga_bounce_gfx_if.slave  vif
);

  localparam logic [10:0] XMAX    = 11'(640 - BOX_W);
  localparam logic [10:0] YMAX    = 11'(480 - BOX_H);
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] BOX_W_W = 11'(BOX_W);
  localparam logic [10:0] BOX_H_W = 11'(BOX_H);
  localparam logic [9:0]  X_INIT  = 10'((640 - BOX_W) / 2);
  localparam logic [9:0]  Y_INIT  = 10'((480 - BOX_H) / 2);

  logic [9:0]  box_x_q, box_x_d;
  logic [9:0]  box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [7:0]  box_color_q, box_color_d;
  logic [7:0]  color_q, color_d;
  logic        frame_tick_q, frame_tick_d;

  logic        strobe;
  logic [10:0] nx, ny, x_w, y_w;

  always_comb begin
    strobe = (vif.hc == 10'd639) && (vif.vc == 10'd479);
    x_w    = {1'b0, box_x_q};
    y_w    = {1'b0, box_y_q};

    // Look one pixel ahead so the registered colour lines up with the next counter value.
    if (vif.hc == 10'd799) begin
      nx = '0;
      ny = (vif.vc == 10'd524) ? '0 : {1'b0, vif.vc} + 11'd1;
    end else begin
      nx = {1'b0, vif.hc} + 11'd1;
      ny = {1'b0, vif.vc};
    end

    if (nx >= 11'd640 || ny >= 11'd480)
      color_d = '0;
`ifdef VGA_BOUNCE_BORDER_EN
    else if (nx == 11'd0 || nx == 11'd639 || ny == 11'd0 || ny == 11'd479)
      color_d = '1;
`endif
    else if (nx >= x_w && nx < x_w + BOX_W_W && ny >= y_w && ny < y_w + BOX_H_W)
      color_d = box_color_q;
    else
      color_d = BG_COLOR;

    frame_tick_d = strobe;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    box_color_d  = box_color_q;

    if (strobe && !vif.pause) begin
      if (dir_x_q) begin
        if (x_w + STEP_W >= XMAX) begin
          box_x_d = XMAX[9:0];
          dir_x_d = 1'b0;
        end else begin
          box_x_d = box_x_q + STEP_W[9:0];
        end
      end else begin
        if (x_w <= STEP_W) begin
          box_x_d = '0;
          dir_x_d = 1'b1;
        end else begin
          box_x_d = box_x_q - STEP_W[9:0];
        end
      end

      if (dir_y_q) begin
        if (y_w + STEP_W >= YMAX) begin
          box_y_d = YMAX[9:0];
          dir_y_d = 1'b0;
        end else begin
          box_y_d = box_y_q + STEP_W[9:0];
        end
      end else begin
        if (y_w <= STEP_W) begin
          box_y_d = '0;
          dir_y_d = 1'b1;
        end else begin
          box_y_d = box_y_q - STEP_W[9:0];
        end
      end

      // A corner hit flips both axes but is still a single bounce event.
      if ((dir_x_d != dir_x_q) || (dir_y_d != dir_y_q))
        box_color_d = {box_color_q[4:0], box_color_q[7:5]};
    end
  end

  always_ff @(posedge vgaclk or negedge rst) begin
    if (!rst) begin
      box_x_q      <= X_INIT;
      box_y_q      <= Y_INIT;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      box_color_q  <= 8'hE0;
      color_q      <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      box_color_q  <= box_color_d;
      color_q      <= color_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign vif.red        = color_q[7:5];
  assign vif.green      = color_q[4:2];
  assign vif.blue       = color_q[1:0];
  assign vif.frame_tick = frame_tick_q;

endmodule

// File: doc/vga_bounce_gfx.md
# vga_bounce_gfx

Pixel-colour generator that sits directly upstream of the VGA timing stage. It takes the stage's free-running `hc_out`/`vc_out` counters and returns an 8-bit RGB332 colour per pixel: a solid box that moves diagonally, bounces off the visible-area edges and changes colour on every bounce. Colour outputs are registered one pixel ahead, so they align with the timing stage's next counter value.

## Interface
- `BOX_W`, 32: box width in pixels; legal range 1..640.
- `BOX_H`, 32: box height in lines; legal range 1..480.
- `STEP`, 2: pixels moved per axis per frame; legal range 1..15, and must be less than both `640-BOX_W` and `480-BOX_H`.
- `BG_COLOR`, 8'h00: background colour, RGB332.
- `vgaclk`  in  1  25 MHz pixel clock.
- `rst`  in  1  Reset; asynchronous, active-low.
- `hc`  in  10  Horizontal counter from the timing stage, 0..799.
- `vc`  in  10  Vertical counter from the timing stage, 0..524.
- `pause`  in  1  While high, box position, direction and colour freeze.
- `red`  out  3  Registered colour, bits [7:5] of RGB332.
- `green`  out  3  Registered colour, bits [4:2].
- `blue`  out  2  Registered colour, bits [1:0].
- `frame_tick`  out  1  One-cycle pulse on each end-of-visible-frame update.

## Operation
- **State.** `box_x` (10 b), `box_y` (10 b), `dir_x`, `dir_y` (1 = increasing), `box_color` (8 b).
- **Reset values.**
  - `box_x` = (640-BOX_W)/2, which is 304 at defaults.
  - `box_y` = (480-BOX_H)/2, which is 224 at defaults.
  - `dir_x` = `dir_y` = 1.
  - `box_color` = 8'hE0.
  - `red`/`green`/`blue` = 0, `frame_tick` = 0.
- **Update strobe.** Asserted in the cycle where `hc`==639 and `vc`==479. At that clock edge:
  - If `pause`=0, positions, directions and colour update as described below.
  - `frame_tick` is registered to 1 for exactly one cycle, whether or not `pause` is high.
- **X axis**, with XMAX = 640-BOX_W:
  - When `dir_x`=1: if `box_x`+STEP ≥ XMAX, then `box_x` becomes XMAX and `dir_x` becomes 0. Otherwise `box_x` becomes `box_x`+STEP.
  - When `dir_x`=0: if `box_x` ≤ STEP, then `box_x` becomes 0 and `dir_x` becomes 1. Otherwise `box_x` becomes `box_x`-STEP.
  - All compares are done at 11-bit width, so there is no wrap-around.
- **Y axis.** Identical rules with YMAX = 480-BOX_H.
- **Bounce colour.**
  - A bounce event is a direction flip on either axis or both.
  - Each bounce event rotates `box_color` left by 3 once: {c[4:0], c[7:5]}.
  - A corner hit, where both axes flip in the same update, still counts as one rotation.
- **Pixel lookahead.**
  - nx = 0 if `hc`==799, else `hc`+1.
  - ny = `vc`, or (`vc`==524 ? 0 : `vc`+1) when `hc`==799.
- **Registered colour.** On each edge the colour output is chosen as follows:
  - 0 when nx≥640 or ny≥480.
  - Otherwise `box_color` when `box_x`≤nx<`box_x`+BOX_W and `box_y`≤ny<`box_y`+BOX_H.
  - Otherwise BG_COLOR.
  - The colour compare uses the pre-update state values. A position update takes visible effect from the next frame's first pixel.
- **Illegal input.** Out-of-range `hc`/`vc` values are not required to produce meaningful output; the only requirement is that no state changes.

## Timing
- Colour latency is exactly 1 cycle. The output present while the timing stage holds (h,v) was computed for (h,v).
- `frame_tick` goes high in the cycle after the strobe cycle, i.e. while `hc`==640 and `vc`==479.
- State updates happen once per frame, during the strobe edge only. The full vertical blank (lines 480..524) therefore sees stable state.
- `pause` is sampled only at the strobe edge. Toggling it mid-frame has no effect until the next strobe.
- Asserting `rst` at any time immediately clears outputs and restores the reset state, with no clock edge needed. After deassertion, the first strobe applies a normal step.

## Configuration
- `VGA_BOUNCE_BORDER_EN` defined:
  - Visible pixels with nx==0, nx==639, ny==0 or ny==479 output 8'hFF.
  - The border overrides both the box and the background.
- `VGA_BOUNCE_BORDER_EN` undefined: no border logic is compiled, and edge pixels follow the normal box/background rule.

## Test plan
- **Reset and first frame.** Drive `rst` low, then release it and step `hc`/`vc` over a full frame. Required: colour 0 during reset. In the first frame, pixel (304,224) = 8'hE0, (303,224) = 8'h00, (336,224) = 8'h00, and every pixel with h≥640 or v≥480 = 0.
- **Frame step.** After one strobe with `pause`=0: `box_x`=306, `box_y`=226, and `frame_tick` is high for one cycle at (640,479). After a second strobe: `box_x`=308, `box_y`=228.
- **Right-edge bounce.** Force state `box_x`=606, `dir_x`=1. After the strobe: `box_x`=608, `dir_x`=0, `box_color` goes from E0 to 07. After the following strobe: `box_x`=606.
- **Corner bounce.** Force state `box_x`=1, `box_y`=1, `dir_x`=0, `dir_y`=0, colour 8'h07. After the strobe: both axes = 0, both directions = 1, colour = 8'h38 (a single rotation only).
- **Pause.** Hold `pause`=1 across 3 strobes. Required: state unchanged, `frame_tick` pulses 3 times, display identical each frame.
- **Border macro and async reset.** With `VGA_BOUNCE_BORDER_EN` defined: pixels (0,100), (639,5) and (200,479) output 8'hFF. Asserting `rst` mid-line clears colour outputs before the next `vgaclk` edge.
